// File: rtl/serial_pkg.sv
// Shared types for the UART transmit queue: byte width and dispatch FSM states.
package serial_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } txq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and a registered level.
module sync_fifo #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_r == FULL_LVL);
    assign empty     = (count_r == {(ADDR_W + 1){1'b0}});
    assign level     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (ADDR_W + 1)'(1);
                2'b01:   count_r <= count_r - (ADDR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/serial_tx_queue.sv
// Byte queue in front of the UART transmitter: buffers CPU writes and issues
// one tx_we pulse per byte, waiting out each transmitter busy period.
module serial_tx_queue
    import serial_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_we,
    input  logic              tx_busy
);

    txq_state_t        state_r;
    txq_state_t        state_nx_s;
    logic [BYTE_W-1:0] tx_data_r;
    logic [BYTE_W-1:0] tx_data_nx_s;
    logic              tx_we_r;
    logic              tx_we_nx_s;
    logic              ovf_r;
    logic              ovf_nx_s;
    logic              pop_s;
    logic              drop_s;
    logic [BYTE_W-1:0] head_s;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop_s),
        .rd_data (head_s),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign tx_data  = tx_data_r;
    assign tx_we    = tx_we_r;
    assign overflow = ovf_r;
    assign drop_s   = wr_en && full && !pop_s;

    // Dispatch next-state: pop the head only when idle and the transmitter is free.
    always_comb begin
        state_nx_s   = state_r;
        tx_data_nx_s = tx_data_r;
        tx_we_nx_s   = 1'b0;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop_s        = 1'b1;
                    tx_we_nx_s   = 1'b1;
                    tx_data_nx_s = head_s;
                    state_nx_s   = ISSUE;
                end else begin
                    state_nx_s   = IDLE;
                end
            end
            ISSUE: begin
                state_nx_s = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_nx_s = WAIT_DONE;
                end else begin
                    state_nx_s = WAIT_START;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT_DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Sticky overflow: a dropped write wins over a simultaneous clear.
    always_comb begin
        if (drop_s) begin
            ovf_nx_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_nx_s = 1'b0;
        end else begin
            ovf_nx_s = ovf_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            tx_data_r <= {BYTE_W{1'b0}};
            tx_we_r   <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            tx_data_r <= tx_data_nx_s;
            tx_we_r   <= tx_we_nx_s;
            ovf_r     <= ovf_nx_s;
        end
    end

endmodule

// File: tb/tb_serial_tx_queue.sv
// Scoreboard bench for serial_tx_queue with a behavioural UART transmitter
// (3 clocks per bit) on tx_data/tx_we/tx_busy.
module tb_serial_tx_queue;

    localparam int DEPTH    = 16;
    localparam int WAIT_DIV = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       busy_hold = 1'b0;
    logic       full, empty, overflow, tx_we, tx_busy;
    logic [4:0] level;
    logic [7:0] tx_data;

    // transmitter model
    logic       txm_busy, txm_line;
    logic [9:0] txm_sh;
    int         txm_tick;

    // reference model and scoreboard
    logic [7:0] ref_q[$];
    logic [7:0] exp_tx[$];
    int         ref_state;
    logic       ref_ovf, ref_we, pop_v, push_v;
    int         acc_cnt = 0, drop_cnt = 0, we_count = 0;
    int         checks = 0, errors = 0;
    logic       mon_en = 1'b0;
    logic [9:0] pat;

    serial_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx_data  (tx_data),
        .tx_we    (tx_we),
        .tx_busy  (tx_busy)
    );

    assign tx_busy = txm_busy | busy_hold;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Transmitter: latches the byte on tx_we, busy from the next cycle for 10 bits.
    always @(posedge clk) begin
        if (!rst) begin
            txm_busy <= 1'b0;
            txm_line <= 1'b1;
            txm_tick <= 0;
        end else if (txm_busy) begin
            if (txm_tick == 10 * WAIT_DIV - 1) begin
                txm_busy <= 1'b0;
                txm_line <= 1'b1;
            end else begin
                txm_tick <= txm_tick + 1;
                txm_line <= txm_sh[(txm_tick + 1) / WAIT_DIV];
            end
        end else if (tx_we) begin
            txm_busy <= 1'b1;
            txm_sh   <= {1'b1, tx_data, 1'b0};
            txm_line <= 1'b0;
            txm_tick <= 0;
        end
    end

    // Cycle reference of the queue behaviour; popped bytes go to the scoreboard.
    always @(posedge clk) begin
        if (!rst) begin
            ref_q.delete();
            exp_tx.delete();
            ref_state = 0;
            ref_ovf   = 1'b0;
            ref_we    = 1'b0;
        end else begin
            pop_v  = (ref_state == 0) && (ref_q.size() != 0) && !tx_busy;
            push_v = wr_en && ((ref_q.size() < DEPTH) || pop_v);
            ref_we = pop_v;
            if (pop_v) exp_tx.push_back(ref_q.pop_front());
            if (push_v) begin
                ref_q.push_back(wr_data);
                acc_cnt++;
            end else if (wr_en) begin
                drop_cnt++;
            end
            if (wr_en && !push_v) ref_ovf = 1'b1;
            else if (ovf_clr) ref_ovf = 1'b0;
            case (ref_state)
                0: if (pop_v) ref_state = 1;
                1: ref_state = 2;
                2: if (tx_busy) ref_state = 3;
                3: if (!tx_busy) ref_state = 0;
                default: ref_state = 0;
            endcase
        end
    end

    // Monitor: compares DUT outputs against the reference every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("level", int'(level), ref_q.size());
            chk("full", int'(full), int'(ref_q.size() == DEPTH));
            chk("empty", int'(empty), int'(ref_q.size() == 0));
            chk("overflow", int'(overflow), int'(ref_ovf));
            chk("tx_we", int'(tx_we), int'(ref_we));
            if (tx_we && tx_busy) chk("we_while_busy", 1, 0);
            if (ref_we && exp_tx.size() != 0) begin
                logic [7:0] e;
                e = exp_tx.pop_front();
                if (tx_we) chk("tx_data", int'(tx_data), int'(e));
            end
            if (tx_we) we_count++;
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(ref_q.size() == 0 && !txm_busy && ref_state == 0 && !tx_we) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("idle_timeout", 0, 1);
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        int we0, acc0, drop0, n;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_level", int'(level), 0);
        chk("rst_tx_we", int'(tx_we), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_empty", int'(empty), 1);
        rst = 1'b1;
        @(negedge clk);

        // 1: single byte, latency and line waveform
        write_byte(8'h55);
        @(negedge clk);
        chk("t1_latency_we", int'(tx_we), 1);
        chk("t1_tx_data", int'(tx_data), 8'h55);
        pat = 10'b1_0101_0101_0;
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 2 : WAIT_DIV) @(negedge clk);
            chk($sformatf("t1_line_bit%0d", i), int'(txm_line), int'(pat[i]));
        end
        wait_idle(200);

        // 2: three back-to-back bytes
        we0 = we_count;
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        wait_idle(500);
        chk("t2_pulses", we_count - we0, 3);
        chk("t2_level", int'(level), 0);

        // 3: fill while transmitter held busy, 17th dropped
        busy_hold = 1'b1;
        for (int i = 0; i < 17; i++) write_byte(8'h10 + 8'(i));
        chk("t3_level", int'(level), 16);
        chk("t3_full", int'(full), 1);
        chk("t3_overflow", int'(overflow), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", int'(overflow), 0);
        chk("t3_level_kept", int'(level), 16);

        // 4: release busy and write on the pop cycle
        busy_hold = 1'b0;
        write_byte(8'hA5);
        chk("t4_level", int'(level), 16);
        chk("t4_overflow", int'(overflow), 0);
        chk("t4_tx_we", int'(tx_we), 1);
        chk("t4_head", int'(tx_data), 8'h10);
        wait_idle(1500);

        // 5: reset mid-frame discards the queue
        for (int i = 0; i < 4; i++) write_byte(8'hC0 + 8'(i));
        n = 0;
        while (!txm_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("t5_start_timeout", 0, 1);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_level", int'(level), 0);
        chk("t5_tx_we", int'(tx_we), 0);
        chk("t5_overflow", int'(overflow), 0);
        chk("t5_line", int'(txm_line), 1);
        rst = 1'b1;
        we0 = we_count;
        repeat (100) @(negedge clk);
        chk("t5_no_frames", we_count - we0, 0);
        chk("t5_line_idle", int'(txm_line), 1);

        // 6: random writes against the scoreboard
        we0 = we_count;
        acc0 = acc_cnt;
        drop0 = drop_cnt;
        for (int i = 0; i < 2000; i++) begin
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        wait_idle(2000);
        chk("t6_rx_eq_accepted", we_count - we0, acc_cnt - acc0);
        chk("t6_drops_seen", int'((drop_cnt - drop0) > 0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
